eblock_allocator: RTL

EBLOCK_ALLOCATOR -- requirements
Module: eblock_allocator

---
 rtl/eblock_allocator.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/eblock_allocator.sv
// E-block ID allocator: tracks busy/owner/PC per e-block slot, grants the lowest
// free ID, and frees IDs on commit or on a whole-CTA flush.
module eblock_allocator #(
    parameter int MAX_NUM_CTA          = 4,
    parameter int MAX_EBLOCK           = 8,
    parameter int PC_WIDTH             = 64,
    parameter int MAX_INFLIGHT_PER_CTA = 2,
    parameter int CTA_ID_WIDTH         = $clog2(MAX_NUM_CTA),
    parameter int EBLOCK_ID_WIDTH      = $clog2(MAX_EBLOCK),
    parameter int CNT_WIDTH            = $clog2(MAX_EBLOCK + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alloc_valid,
    input  logic [CTA_ID_WIDTH-1:0]            alloc_cta_id,
    input  logic [PC_WIDTH-1:0]                alloc_pc,
    output logic                               alloc_ready,
    output logic [EBLOCK_ID_WIDTH-1:0]         alloc_eblock_id,
    input  logic                               commit_valid,
    input  logic [EBLOCK_ID_WIDTH-1:0]         commit_eblock_id,
    input  logic                               flush_valid,
    input  logic [CTA_ID_WIDTH-1:0]            flush_cta_id,
    input  logic [EBLOCK_ID_WIDTH-1:0]         lookup_eblock_id,
    output logic                               lookup_valid,
    output logic [CTA_ID_WIDTH-1:0]            lookup_cta_id,
    output logic [PC_WIDTH-1:0]                lookup_pc,
    output logic [CNT_WIDTH-1:0]               free_count,
    output logic [MAX_NUM_CTA*CNT_WIDTH-1:0]   cta_inflight,
    output logic                               err_bad_commit
);

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [MAX_EBLOCK-1:0] vec);
        logic [CNT_WIDTH-1:0] sum;
        sum = {CNT_WIDTH{1'b0}};
        for (int i = 0; i < MAX_EBLOCK; i++) begin
            sum = sum + CNT_WIDTH'(vec[i]);
        end
        return sum;
    endfunction

    logic [MAX_EBLOCK-1:0]    busy_r;
    logic [CTA_ID_WIDTH-1:0]  owner_r [MAX_EBLOCK];
    logic [PC_WIDTH-1:0]      pc_r    [MAX_EBLOCK];
    logic [CNT_WIDTH-1:0]     cnt_r   [MAX_NUM_CTA];
    logic                     err_r;
    logic [CNT_WIDTH-1:0]     free_count_r;

    logic [MAX_EBLOCK-1:0]    busy_nxt_s;
    logic [CTA_ID_WIDTH-1:0]  owner_nxt_s [MAX_EBLOCK];
    logic [PC_WIDTH-1:0]      pc_nxt_s    [MAX_EBLOCK];
    logic [CNT_WIDTH-1:0]     cnt_nxt_s   [MAX_NUM_CTA];
    logic                     err_nxt_s;

    logic                       any_free_s;
    logic [EBLOCK_ID_WIDTH-1:0] free_idx_s;
    logic                       ready_s;
    logic                       grant_s;
    logic                       commit_hit_s;
    logic                       commit_dec_s;
    logic                       bad_commit_s;
    logic [CTA_ID_WIDTH-1:0]    commit_owner_s;

    // Lowest-index free entry; scanning downward lets the lowest index win.
    always_comb begin
        any_free_s = 1'b0;
        free_idx_s = {EBLOCK_ID_WIDTH{1'b0}};
        for (int i = MAX_EBLOCK - 1; i >= 0; i--) begin
            if (!busy_r[i]) begin
                any_free_s = 1'b1;
                free_idx_s = EBLOCK_ID_WIDTH'(i);
            end else begin
                any_free_s = any_free_s;
            end
        end
    end

    // Handshake and commit classification, all from start-of-cycle state.
    always_comb begin
        ready_s        = any_free_s
                         && (cnt_r[alloc_cta_id] < CNT_WIDTH'(MAX_INFLIGHT_PER_CTA))
                         && !(flush_valid && (flush_cta_id == alloc_cta_id));
        grant_s        = alloc_valid && ready_s;
        commit_owner_s = owner_r[commit_eblock_id];
        commit_hit_s   = commit_valid && busy_r[commit_eblock_id];
        bad_commit_s   = commit_valid && !busy_r[commit_eblock_id];
        // A commit absorbed by a flush of its owner must not decrement again.
        if (commit_hit_s && flush_valid && (commit_owner_s == flush_cta_id)) begin
            commit_dec_s = 1'b0;
        end else begin
            commit_dec_s = commit_hit_s;
        end
    end

    // Next-state table: grant sets a free entry, commit/flush clear busy ones.
    always_comb begin
        busy_nxt_s = busy_r;
        err_nxt_s  = err_r | bad_commit_s;
        for (int i = 0; i < MAX_EBLOCK; i++) begin
            owner_nxt_s[i] = owner_r[i];
            pc_nxt_s[i]    = pc_r[i];
            if (grant_s && (free_idx_s == EBLOCK_ID_WIDTH'(i))) begin
                busy_nxt_s[i]  = 1'b1;
                owner_nxt_s[i] = alloc_cta_id;
                pc_nxt_s[i]    = alloc_pc;
            end else if ((commit_hit_s && (commit_eblock_id == EBLOCK_ID_WIDTH'(i)))
                         || (flush_valid && busy_r[i] && (owner_r[i] == flush_cta_id))) begin
                busy_nxt_s[i]  = 1'b0;
                owner_nxt_s[i] = {CTA_ID_WIDTH{1'b0}};
                pc_nxt_s[i]    = {PC_WIDTH{1'b0}};
            end else begin
                busy_nxt_s[i]  = busy_r[i];
            end
        end
    end

    // Per-CTA outstanding counts; alloc and commit on one CTA cancel out.
    always_comb begin
        for (int c = 0; c < MAX_NUM_CTA; c++) begin
            logic inc_v;
            logic dec_v;
            inc_v = grant_s && (alloc_cta_id == CTA_ID_WIDTH'(c));
            dec_v = commit_dec_s && (commit_owner_s == CTA_ID_WIDTH'(c));
            if (flush_valid && (flush_cta_id == CTA_ID_WIDTH'(c))) begin
                cnt_nxt_s[c] = {CNT_WIDTH{1'b0}};
            end else if (inc_v && !dec_v) begin
                cnt_nxt_s[c] = cnt_r[c] + CNT_WIDTH'(1);
            end else if (dec_v && !inc_v) begin
                cnt_nxt_s[c] = cnt_r[c] - CNT_WIDTH'(1);
            end else begin
                cnt_nxt_s[c] = cnt_r[c];
            end
        end
    end

    // State registers with synchronous reset taking priority over all requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r       <= {MAX_EBLOCK{1'b0}};
            err_r        <= 1'b0;
            free_count_r <= CNT_WIDTH'(MAX_EBLOCK);
            for (int i = 0; i < MAX_EBLOCK; i++) begin
                owner_r[i] <= {CTA_ID_WIDTH{1'b0}};
                pc_r[i]    <= {PC_WIDTH{1'b0}};
            end
            for (int c = 0; c < MAX_NUM_CTA; c++) begin
                cnt_r[c] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            busy_r       <= busy_nxt_s;
            err_r        <= err_nxt_s;
            free_count_r <= CNT_WIDTH'(MAX_EBLOCK) - popcount(busy_nxt_s);
            for (int i = 0; i < MAX_EBLOCK; i++) begin
                owner_r[i] <= owner_nxt_s[i];
                pc_r[i]    <= pc_nxt_s[i];
            end
            for (int c = 0; c < MAX_NUM_CTA; c++) begin
                cnt_r[c] <= cnt_nxt_s[c];
            end
        end
    end

    // Output mapping; lookup fields are masked to zero for idle entries.
    always_comb begin
        alloc_ready     = ready_s;
        alloc_eblock_id = free_idx_s;
        free_count      = free_count_r;
        err_bad_commit  = err_r;
        lookup_valid    = busy_r[lookup_eblock_id];
        if (busy_r[lookup_eblock_id]) begin
            lookup_cta_id = owner_r[lookup_eblock_id];
            lookup_pc     = pc_r[lookup_eblock_id];
        end else begin
            lookup_cta_id = {CTA_ID_WIDTH{1'b0}};
            lookup_pc     = {PC_WIDTH{1'b0}};
        end
        for (int c = 0; c < MAX_NUM_CTA; c++) begin
            cta_inflight[c*CNT_WIDTH +: CNT_WIDTH] = cnt_r[c];
        end
    end

endmodule
